uart_tx_arbiter: RTL and testbench



---
 rtl/uart_arb_pkg.sv | 8 +
 rtl/rr_arbiter.sv | 25 ++
 rtl/uart_tx_arbiter.sv | 108 ++++++++++
 tb/tb_uart_tx_arbiter.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg: shared FSM state type, reset baud divider and grant-index width helper.
package uart_arb_pkg;
  typedef enum logic [1:0] {IDLE, START, WAIT_DONE, GAP} state_e;
  localparam int DEFAULT_CLKDIV = 867;
  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first set request at or above ptr, with wrap.
module rr_arbiter import uart_arb_pkg::*; #(
  parameter int N_REQ = 4,
  parameter int W = id_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [W-1:0]     ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [W-1:0]     idx
);
  always_comb begin
    logic [W-1:0] j;
    gnt = '0;
    idx = '0;
    j = '0;
    // Scan farthest offset first so the candidate nearest ptr is written last and wins.
    for (int i = N_REQ - 1; i >= 0; i--) begin
      j = W'((int'(ptr) + i) % N_REQ);
      if (req[j]) begin
        gnt = N_REQ'(1) << j;
        idx = j;
      end
    end
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one uart_tx between requesters, with DONE timeout and inter-frame gap.
module uart_tx_arbiter #(
  parameter int N_REQ = 4,
  parameter int CLKDIV_W = 16,
  parameter logic [CLKDIV_W-1:0] DEFAULT_CLKDIV = CLKDIV_W'(uart_arb_pkg::DEFAULT_CLKDIV),
  parameter int GAP_CYCLES = 16,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic                                  CLK,
  input  logic                                  SRST,
  input  logic [N_REQ-1:0]                      REQ_VALID,
  input  logic [8*N_REQ-1:0]                    REQ_DATA,
  output logic [N_REQ-1:0]                      REQ_READY,
  input  logic [CLKDIV_W-1:0]                   CFG_CLKDIV,
  output logic                                  TX_ENA,
  output logic [7:0]                            TX_DATA,
  output logic [CLKDIV_W-1:0]                   TX_CLKDIV,
  input  logic                                  TX_DONE,
  output logic                                  BUSY,
  output logic [uart_arb_pkg::id_w(N_REQ)-1:0]  GRANT_ID,
  output logic                                  ERR_TIMEOUT
);
  import uart_arb_pkg::*;
  localparam int W = id_w(N_REQ);
  localparam int CNT_MAX = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
  localparam int CNT_W = $clog2(CNT_MAX + 1);
  localparam state_e AFTER_WAIT = (GAP_CYCLES == 0) ? IDLE : GAP;
  state_e state_q, state_d;
  logic [W-1:0] ptr_q, ptr_d, gid_q, gid_d, idx;
  logic [7:0] data_q, data_d;
  logic [CLKDIV_W-1:0] clkdiv_q, clkdiv_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic done_q, done_d, err;
  logic [N_REQ-1:0] gnt;
  rr_arbiter #(.N_REQ(N_REQ), .W(W)) u_rr (
    .req(REQ_VALID),
    .ptr(ptr_q),
    .gnt(gnt),
    .idx(idx)
  );
  assign REQ_READY   = (state_q == IDLE && !SRST) ? gnt : '0;
  assign TX_ENA      = state_q == START && !SRST;
  assign BUSY        = state_q != IDLE && !SRST;
  assign ERR_TIMEOUT = err && !SRST;
  assign TX_DATA     = data_q;
  assign TX_CLKDIV   = clkdiv_q;
  assign GRANT_ID    = gid_q;
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    gid_d    = gid_q;
    data_d   = data_q;
    clkdiv_d = clkdiv_q;
    cnt_d    = cnt_q;
    done_d   = TX_DONE;
    err      = 1'b0;
    case (state_q)
      IDLE: begin
        clkdiv_d = CFG_CLKDIV;
        if (|gnt) begin
          data_d  = REQ_DATA[{idx, 3'b000} +: 8];
          gid_d   = idx;
          ptr_d   = (idx == W'(N_REQ - 1)) ? '0 : idx + 1'b1;
          state_d = START;
        end
      end
      START: begin
        cnt_d   = '0;
        state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (TX_DONE && !done_q) begin
          cnt_d   = '0;
          state_d = AFTER_WAIT;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          err     = 1'b1;
          cnt_d   = '0;
          state_d = AFTER_WAIT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        cnt_d   = (cnt_q == CNT_W'(GAP_CYCLES - 1)) ? '0 : cnt_q + 1'b1;
        state_d = (cnt_q == CNT_W'(GAP_CYCLES - 1)) ? IDLE : GAP;
      end
    endcase
  end
  always_ff @(posedge CLK) begin
    if (SRST) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      gid_q    <= '0;
      data_q   <= '0;
      clkdiv_q <= DEFAULT_CLKDIV;
      cnt_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      gid_q    <= gid_d;
      data_q   <= data_d;
      clkdiv_q <= clkdiv_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed checks of grant order, latency, gap, timeout, baud update and reset.
module tb_uart_tx_arbiter;
  logic CLK = 1'b0;
  logic SRST = 1'b1;
  logic [3:0] VALID = '0;
  logic [31:0] DATA = '0;
  logic [15:0] CFG = 16'd867;
  logic DONE = 1'b0;
  logic [3:0] READY;
  logic ENA, BUSY, ERR;
  logic [7:0] TXD;
  logic [15:0] TXDIV;
  logic [1:0] GID;
  int ncmp = 0;
  int nfail = 0;
  int n;
  always #5 CLK = ~CLK;
  uart_tx_arbiter #(
    .N_REQ(4), .CLKDIV_W(16), .DEFAULT_CLKDIV(16'd867), .GAP_CYCLES(4), .TIMEOUT_CYCLES(100)
  ) dut (
    .CLK(CLK), .SRST(SRST), .REQ_VALID(VALID), .REQ_DATA(DATA), .REQ_READY(READY),
    .CFG_CLKDIV(CFG), .TX_ENA(ENA), .TX_DATA(TXD), .TX_CLKDIV(TXDIV), .TX_DONE(DONE),
    .BUSY(BUSY), .GRANT_ID(GID), .ERR_TIMEOUT(ERR)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask
  task automatic do_reset();
    SRST = 1'b1;
    tick();
    tick();
    SRST = 1'b0;
    #1;
  endtask
  task automatic serve(input int id, input logic [7:0] d, input bit drop);
    int k;
    #1;
    k = 0;
    while (READY == 4'b0 && k < 50) begin
      tick();
      k++;
    end
    chk("ready_onehot", 32'(READY), 32'(4'b1 << id));
    tick();
    if (drop) VALID[id] = 1'b0;
    chk("ena_start", 32'(ENA), 1);
    chk("tx_data", 32'(TXD), 32'(d));
    chk("grant_id", 32'(GID), 32'(id));
    chk("ready_busy", 32'(READY), 0);
    DONE = 1'b0;
    tick();
    chk("ena_single", 32'(ENA), 0);
    tick();
    DONE = 1'b1;
    tick();
    k = 0;
    while (BUSY && k < 50) begin
      tick();
      k++;
    end
    chk("gap_len", k, 4);
  endtask
  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    do_reset();
    chk("rst_ready", 32'(READY), 0);
    chk("rst_ena", 32'(ENA), 0);
    chk("rst_data", 32'(TXD), 0);
    chk("rst_clkdiv", 32'(TXDIV), 867);
    chk("rst_busy", 32'(BUSY), 0);
    chk("rst_gid", 32'(GID), 0);
    chk("rst_err", 32'(ERR), 0);
    VALID = 4'b0001;
    DATA[7:0] = 8'hAB;
    serve(0, 8'hAB, 1'b1);
    do_reset();
    VALID = 4'b1111;
    DATA = 32'h13121110;
    serve(0, 8'h10, 1'b0);
    serve(1, 8'h11, 1'b0);
    serve(2, 8'h12, 1'b0);
    serve(3, 8'h13, 1'b0);
    serve(0, 8'h10, 1'b1);
    VALID = 4'b0000;
    do_reset();
    VALID = 4'b1010;
    DATA = 32'hB300B100;
    serve(1, 8'hB1, 1'b0);
    serve(3, 8'hB3, 1'b0);
    serve(1, 8'hB1, 1'b0);
    serve(3, 8'hB3, 1'b1);
    VALID = 4'b0000;
    DATA[7:0] = 8'h5A;
    DONE = 1'b0;
    tick();
    VALID = 4'b0001;
    #1;
    chk("to_ready", 32'(READY), 1);
    tick();
    VALID = 4'b0000;
    chk("to_ena", 32'(ENA), 1);
    chk("to_data", 32'(TXD), 32'h5A);
    n = 0;
    while (!ERR && n < 200) begin
      tick();
      n++;
    end
    chk("to_latency", n, 100);
    tick();
    chk("to_err_pulse", 32'(ERR), 0);
    chk("to_gap_busy", 32'(BUSY), 1);
    n = 1;
    while (BUSY && n < 50) begin
      tick();
      n++;
    end
    chk("to_gap_exit", n, 5);
    VALID = 4'b0100;
    DATA[23:16] = 8'hC3;
    serve(2, 8'hC3, 1'b1);
    VALID = 4'b0001;
    DATA[7:0] = 8'hE1;
    #1;
    chk("cfg_ready", 32'(READY), 1);
    tick();
    VALID = 4'b0000;
    CFG = 16'd433;
    chk("cfg_gid", 32'(GID), 0);
    chk("cfg_start", 32'(TXDIV), 867);
    DONE = 1'b0;
    tick();
    tick();
    chk("cfg_wait", 32'(TXDIV), 867);
    DONE = 1'b1;
    tick();
    chk("cfg_gap", 32'(TXDIV), 867);
    n = 0;
    while (BUSY && n < 50) begin
      tick();
      n++;
    end
    chk("cfg_first_idle", 32'(TXDIV), 867);
    tick();
    chk("cfg_applied", 32'(TXDIV), 433);
    VALID = 4'b0100;
    DATA[23:16] = 8'h77;
    #1;
    chk("mr_ready", 32'(READY), 32'h4);
    tick();
    chk("mr_ena", 32'(ENA), 1);
    DATA[23:16] = 8'h88;
    tick();
    chk("mr_wait_busy", 32'(BUSY), 1);
    SRST = 1'b1;
    #1;
    chk("mr_no_ready_srst", 32'(READY), 0);
    tick();
    chk("mr_no_accept_srst", 32'(READY), 0);
    tick();
    SRST = 1'b0;
    #1;
    chk("mr_ena", 32'(ENA), 0);
    chk("mr_data", 32'(TXD), 0);
    chk("mr_clkdiv", 32'(TXDIV), 867);
    chk("mr_busy", 32'(BUSY), 0);
    chk("mr_gid", 32'(GID), 0);
    chk("mr_err", 32'(ERR), 0);
    VALID = 4'b1100;
    DATA[31:24] = 8'h99;
    serve(2, 8'h88, 1'b1);
    VALID = 4'b0000;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
